// File: rtl/config_fifo_pkg.sv
// Shared types and default sizing for the config FIFO responder.
package config_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/config_fifo_if.sv
// Config bus between initiator (master) and FIFO responder (slave).
// Optional error flags appear when CONFIG_FIFO_RESP_ERR_EN is defined.
interface config_fifo_if
    import config_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) ();

    logic                         w_en;
    logic [DATA_WIDTH-1:0]        write_data;
    logic                         r_en;
    logic [DATA_WIDTH-1:0]        read_data;
    logic                         read_valid;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
`ifdef CONFIG_FIFO_RESP_ERR_EN
    logic                         overflow;
    logic                         underflow;

    modport master (
        output w_en, write_data, r_en,
        input  read_data, read_valid, count, full, empty, overflow, underflow
    );

    modport slave (
        input  w_en, write_data, r_en,
        output read_data, read_valid, count, full, empty, overflow, underflow
    );
`else
    modport master (
        output w_en, write_data, r_en,
        input  read_data, read_valid, count, full, empty
    );

    modport slave (
        input  w_en, write_data, r_en,
        output read_data, read_valid, count, full, empty
    );
`endif

endinterface

// File: rtl/config_fifo_mem.sv
// FIFO storage: one write port and a registered read port.
// The read register resets to zero; the array itself is not reset.
module config_fifo_mem
    import config_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [$clog2(DEPTH)-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          re,
    input  logic [$clog2(DEPTH)-1:0]      raddr,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Array write; a same-edge read of the same slot sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port, holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/config_fifo_responder.sv
// Config bus responder that queues writes in a DEPTH-entry FIFO and
// returns them in order on reads, with occupancy status.
// Optional sticky overflow/underflow flags: CONFIG_FIFO_RESP_ERR_EN.
//
// state   | meaning
// --------+------------------------------------------
// EMPTY   | no entries, pops rejected
// PARTIAL | 1..DEPTH-1 entries, push and pop accepted
// FULL    | DEPTH entries, push only with a same-cycle pop
module config_fifo_responder
    import config_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    config_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    occ_state_t            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  push_ok, pop_ok;
    logic                  read_valid_q;
    logic [DATA_WIDTH-1:0] rdata;

    // Accept decisions; a full FIFO takes a push only when it also pops.
    always_comb begin
        pop_ok  = bus.r_en && (state_q != EMPTY);
        push_ok = bus.w_en && ((state_q != FULL) || pop_ok);
    end

    // Occupancy next-state and count update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        case (state_q)
            EMPTY: begin
                if (push_ok) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (push_ok && !pop_ok && count_q == CNT_W'(DEPTH-1)) begin
                    state_d = FULL;
                end else if (pop_ok && !push_ok && count_q == CNT_W'(1)) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop_ok && !push_ok) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, count, pointers and read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            read_valid_q <= pop_ok;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    config_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.write_data),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign bus.read_data  = rdata;
    assign bus.read_valid = read_valid_q;
    assign bus.count      = count_q;
    assign bus.full       = (state_q == FULL);
    assign bus.empty      = (state_q == EMPTY);

`ifdef CONFIG_FIFO_RESP_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.w_en && !push_ok) overflow_q  <= 1'b1;
            if (bus.r_en && !pop_ok)  underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule
